i2c_apb_regs: RTL and testbench

APB3 slave register block for the I2C controller: decodes APB transfers from the host bus into control/config registers and byte FIFOs feeding the I2C core. It sits directly in front of the APB protocol checker on `intf_i2c` and is the sole driver of `prdata`, `pready` and `pslverr`. `prdata` must be held stable for every cycle in which `psel & penable` is high.

---
 rtl/i2c_apb_pkg.sv | 38 +++
 rtl/i2c_sync_fifo.sv | 52 +++++
 rtl/i2c_apb_regs.sv | 229 ++++++++++++++++++++++
 tb/tb_i2c_apb_regs.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_apb_pkg.sv
// Shared constants for the I2C APB register block: register indices, STATUS/CTRL
// bit positions, APB FSM states and the PRESCALE reset value.
package i2c_apb_pkg;

  localparam int unsigned REG_IDX_W = 3;

  localparam logic [7:0] ADDR_CTRL     = 8'h00;
  localparam logic [7:0] ADDR_SADDR    = 8'h04;
  localparam logic [7:0] ADDR_PRESCALE = 8'h08;
  localparam logic [7:0] ADDR_STATUS   = 8'h0C;
  localparam logic [7:0] ADDR_TXDATA   = 8'h10;
  localparam logic [7:0] ADDR_RXDATA   = 8'h14;

  // Word index as seen on paddr[4:2]
  localparam logic [REG_IDX_W-1:0] IDX_CTRL     = REG_IDX_W'(ADDR_CTRL >> 2);
  localparam logic [REG_IDX_W-1:0] IDX_SADDR    = REG_IDX_W'(ADDR_SADDR >> 2);
  localparam logic [REG_IDX_W-1:0] IDX_PRESCALE = REG_IDX_W'(ADDR_PRESCALE >> 2);
  localparam logic [REG_IDX_W-1:0] IDX_STATUS   = REG_IDX_W'(ADDR_STATUS >> 2);
  localparam logic [REG_IDX_W-1:0] IDX_TXDATA   = REG_IDX_W'(ADDR_TXDATA >> 2);
  localparam logic [REG_IDX_W-1:0] IDX_RXDATA   = REG_IDX_W'(ADDR_RXDATA >> 2);

  localparam int unsigned CTRL_EN_BIT     = 0;
  localparam int unsigned CTRL_IRQ_EN_BIT = 1;

  localparam int unsigned ST_TX_FULL  = 0;
  localparam int unsigned ST_TX_EMPTY = 1;
  localparam int unsigned ST_RX_FULL  = 2;
  localparam int unsigned ST_RX_EMPTY = 3;
  localparam int unsigned ST_RX_OVF   = 4;

  localparam logic [15:0] PRESCALE_RST = 16'h0063;

  typedef enum logic {
    APB_IDLE,
    APB_ACCESS
  } apb_state_e;

endpackage

// File: rtl/i2c_sync_fifo.sv
// Single-clock byte FIFO with full/empty flags; push while full is accepted only
// when a pop happens in the same cycle. Head reads 0 while empty.
module i2c_sync_fifo
  import i2c_apb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? '0 : mem[rptr];

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_W'(1);
      if (do_pop)  rptr <= rptr + PTR_W'(1);
      cnt <= cnt + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/i2c_apb_regs.sv
// APB3 slave register block for the I2C controller (CTRL/SADDR/PRESCALE/STATUS
// plus TX/RX byte FIFOs). Define I2C_APB_PSLVERR_EN to report bad accesses on pslverr.
module i2c_apb_regs
  import i2c_apb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic              apb_clk,
  input  logic              preset_n,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              ctrl_en,
  output logic [6:0]        slave_addr,
  output logic [15:0]       prescale,
  output logic              irq
);

  localparam int unsigned WCNT_W = 3;

  apb_state_e           state, state_nxt;
  logic [WCNT_W-1:0]    wcnt, wcnt_nxt;
  logic                 setup_c;
  logic                 commit_c;
  logic                 addr_ok_c;
  logic [31:0]          rd_decode_c;

  logic [31:0]          hold_rdata;
  logic [REG_IDX_W-1:0] hold_idx;
  logic                 hold_write;
  logic                 hold_addr_ok;
  logic                 hold_rx_avail;

  logic                 irq_en;
  logic                 rx_ovf;
  logic                 wr_c;
  logic                 rd_c;

  logic                 tx_push_c, tx_pop_c, tx_full, tx_empty;
  logic                 rx_pop_c, rx_full, rx_empty;
  logic [7:0]           rx_head;

  logic                 unused_bits;
  assign unused_bits = ^{pwdata[31:16], paddr[1:0]};

  assign setup_c   = psel & ~penable;
  assign addr_ok_c = ((paddr >> 5) == ADDR_W'(0)) && (paddr[4:2] <= IDX_RXDATA);

  // APB state register
  always_ff @(posedge apb_clk or negedge preset_n) begin
    if (!preset_n) begin
      state <= APB_IDLE;
      wcnt  <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  // Next state, wait-state countdown and commit strobe
  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    pready    = 1'b0;
    commit_c  = 1'b0;
    case (state)
      APB_IDLE: begin
        if (setup_c) begin
          state_nxt = APB_ACCESS;
          wcnt_nxt  = WCNT_W'(WAIT_STATES);
        end
      end
      APB_ACCESS: begin
        pready = (wcnt == '0);
        if (!psel) begin
          state_nxt = APB_IDLE;
        end else if (wcnt == '0) begin
          commit_c  = 1'b1;
          state_nxt = APB_IDLE;
        end else begin
          wcnt_nxt = wcnt - WCNT_W'(1);
        end
      end
      default: state_nxt = APB_IDLE;
    endcase
  end

  // Live read decode of paddr
  always_comb begin
    rd_decode_c = '0;
    if (addr_ok_c) begin
      case (paddr[4:2])
        IDX_CTRL: begin
          rd_decode_c[CTRL_EN_BIT]     = ctrl_en;
          rd_decode_c[CTRL_IRQ_EN_BIT] = irq_en;
        end
        IDX_SADDR:    rd_decode_c[6:0]  = slave_addr;
        IDX_PRESCALE: rd_decode_c[15:0] = prescale;
        IDX_STATUS: begin
          rd_decode_c[ST_TX_FULL]  = tx_full;
          rd_decode_c[ST_TX_EMPTY] = tx_empty;
          rd_decode_c[ST_RX_FULL]  = rx_full;
          rd_decode_c[ST_RX_EMPTY] = rx_empty;
          rd_decode_c[ST_RX_OVF]   = rx_ovf;
        end
        IDX_RXDATA:   rd_decode_c[7:0] = rx_head;
        default:      rd_decode_c = '0;
      endcase
    end
  end

  // Transfer attributes frozen at the SETUP edge so wait states cannot disturb them
  always_ff @(posedge apb_clk or negedge preset_n) begin
    if (!preset_n) begin
      hold_rdata    <= '0;
      hold_idx      <= '0;
      hold_write    <= 1'b0;
      hold_addr_ok  <= 1'b0;
      hold_rx_avail <= 1'b0;
    end else if (state == APB_IDLE && setup_c) begin
      hold_rdata    <= pwrite ? 32'h0 : rd_decode_c;
      hold_idx      <= paddr[4:2];
      hold_write    <= pwrite;
      hold_addr_ok  <= addr_ok_c;
      hold_rx_avail <= ~rx_empty;
    end
  end

  always_comb begin
    prdata = '0;
    if (state == APB_ACCESS) begin
      prdata = hold_rdata;
    end else if (setup_c && !pwrite) begin
      prdata = rd_decode_c;
    end
  end

  assign wr_c      = commit_c & hold_write & hold_addr_ok;
  assign rd_c      = commit_c & ~hold_write & hold_addr_ok;
  assign tx_pop_c  = tx_valid & tx_ready;
  assign tx_push_c = wr_c & (hold_idx == IDX_TXDATA);
  // Only APB pops RX, so a byte present at SETUP is still there at commit
  assign rx_pop_c  = rd_c & (hold_idx == IDX_RXDATA) & hold_rx_avail;
  assign tx_valid  = ~tx_empty;

`ifdef I2C_APB_PSLVERR_EN
  logic err_c;
  always_comb begin
    err_c = 1'b0;
    if (!hold_addr_ok) begin
      err_c = 1'b1;
    end else if (hold_write) begin
      err_c = (hold_idx == IDX_RXDATA) ||
              (hold_idx == IDX_TXDATA && tx_full && !tx_pop_c);
    end else begin
      err_c = (hold_idx == IDX_TXDATA) ||
              (hold_idx == IDX_RXDATA && !hold_rx_avail);
    end
  end
  assign pslverr = commit_c & err_c;
`else
  assign pslverr = 1'b0;
`endif

  // Control registers, sticky overflow and interrupt
  always_ff @(posedge apb_clk or negedge preset_n) begin
    if (!preset_n) begin
      ctrl_en    <= 1'b0;
      irq_en     <= 1'b0;
      slave_addr <= '0;
      prescale   <= PRESCALE_RST;
      rx_ovf     <= 1'b0;
      irq        <= 1'b0;
    end else begin
      if (wr_c) begin
        case (hold_idx)
          IDX_CTRL: begin
            ctrl_en <= pwdata[CTRL_EN_BIT];
            irq_en  <= pwdata[CTRL_IRQ_EN_BIT];
          end
          IDX_SADDR:    slave_addr <= pwdata[6:0];
          IDX_PRESCALE: prescale   <= pwdata[15:0];
          default: ;
        endcase
      end
      if (rx_valid && rx_full && !rx_pop_c) begin
        rx_ovf <= 1'b1;
      end else if (wr_c && hold_idx == IDX_STATUS && pwdata[ST_RX_OVF]) begin
        rx_ovf <= 1'b0;
      end
      irq <= irq_en & (~rx_empty | rx_ovf);
    end
  end

  i2c_sync_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_tx_fifo (
    .clk   (apb_clk),
    .rst_n (preset_n),
    .push  (tx_push_c),
    .pop   (tx_pop_c),
    .wdata (pwdata[7:0]),
    .rdata (tx_data),
    .full  (tx_full),
    .empty (tx_empty)
  );

  i2c_sync_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_rx_fifo (
    .clk   (apb_clk),
    .rst_n (preset_n),
    .push  (rx_valid),
    .pop   (rx_pop_c),
    .wdata (rx_data),
    .rdata (rx_head),
    .full  (rx_full),
    .empty (rx_empty)
  );

endmodule

// File: tb/tb_i2c_apb_regs.sv
// Scoreboard bench for i2c_apb_regs with three wait states; expected pslverr
// follows whether I2C_APB_PSLVERR_EN is defined.
module tb_i2c_apb_regs;

  localparam int unsigned WS = 3;
`ifdef I2C_APB_PSLVERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        apb_clk, preset_n;
  logic        psel, penable, pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr;
  logic [7:0]  tx_data, rx_data;
  logic        tx_valid, tx_ready, rx_valid;
  logic        ctrl_en, irq;
  logic [6:0]  slave_addr;
  logic [15:0] prescale;

  i2c_apb_regs #(.ADDR_W(8), .FIFO_DEPTH(4), .WAIT_STATES(WS)) dut (
    .apb_clk(apb_clk), .preset_n(preset_n), .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
    .pready(pready), .pslverr(pslverr), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .ctrl_en(ctrl_en),
    .slave_addr(slave_addr), .prescale(prescale), .irq(irq)
  );

  initial apb_clk = 1'b0;
  always #5 apb_clk = ~apb_clk;

  typedef struct {
    bit          is_read;
    logic [31:0] rdata;
    bit          err;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, expv);
    end
  endtask

  // Monitor: on each completed transfer pop the expectation and compare
  int          acc_cycles = 0;
  logic [31:0] first_prdata;
  bit          stable = 1'b1;
  exp_t        mon_e;
  string       mon_nm;

  always @(negedge apb_clk) begin
    if (!preset_n || !(psel && penable)) begin
      acc_cycles = 0;
      stable     = 1'b1;
    end else begin
      if (acc_cycles == 0) first_prdata = prdata;
      else if (prdata !== first_prdata) stable = 1'b0;
      acc_cycles++;
      if (pready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_xfer: got completion expected none");
        end else begin
          mon_e  = exp_q.pop_front();
          mon_nm = name_q.pop_front();
          chk({mon_nm, "_waits"}, 32'(acc_cycles - 1), 32'(WS));
          chk({mon_nm, "_pslverr"}, {31'h0, pslverr}, {31'h0, mon_e.err});
          if (mon_e.is_read) begin
            chk({mon_nm, "_rdata"}, prdata, mon_e.rdata);
            chk({mon_nm, "_stable"}, {31'h0, stable}, 32'h1);
          end
        end
      end
    end
  end

  task automatic apb(input bit wr, input logic [7:0] a, input logic [31:0] d,
                     input logic [31:0] exp_rd, input bit exp_err, input string nm,
                     input bit rx_at_commit = 1'b0, input logic [7:0] rx_byte = 8'h00);
    exp_t e;
    bit   done;
    @(posedge apb_clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    e.is_read = !wr; e.rdata = exp_rd; e.err = exp_err;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge apb_clk); #1;
    penable = 1'b1;
    done = 1'b0;
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge apb_clk);
      done = pready;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no pready expected pready within 20 cycles", nm);
      void'(exp_q.pop_back());
      void'(name_q.pop_back());
    end
    if (rx_at_commit) begin
      rx_valid = 1'b1;
      rx_data  = rx_byte;
    end
    @(posedge apb_clk); #1;
    psel = 1'b0; penable = 1'b0; rx_valid = 1'b0;
  endtask

  logic [7:0] txb [5];
  logic [7:0] rxb [5];

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    txb = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    rxb = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0;
    tx_ready = 0; rx_data = 0; rx_valid = 0; preset_n = 0;
    repeat (3) @(negedge apb_clk);
    preset_n = 1'b1;
    @(negedge apb_clk);
    chk("rst_prdata", prdata, 32'h0);
    chk("rst_pready", {31'h0, pready}, 32'h0);
    chk("rst_pslverr", {31'h0, pslverr}, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    chk("rst_prescale", {16'h0, prescale}, 32'h63);
    chk("rst_tx_valid", {31'h0, tx_valid}, 32'h0);

    apb(0, 8'h08, 0, 32'h63, 0, "rd_prescale_rst");
    apb(0, 8'h0C, 0, 32'h0A, 0, "rd_status_rst");
    apb(1, 8'h04, 32'h5A, 0, 0, "wr_saddr");
    @(negedge apb_clk) chk("saddr_out", {25'h0, slave_addr}, 32'h5A);
    apb(0, 8'h04, 0, 32'h5A, 0, "rd_saddr");
    apb(1, 8'h00, 32'h3, 0, 0, "wr_ctrl");
    @(negedge apb_clk) chk("ctrl_en_out", {31'h0, ctrl_en}, 32'h1);
    apb(0, 8'h00, 0, 32'h3, 0, "rd_ctrl");
    apb(1, 8'h08, 32'h1234ABCD, 0, 0, "wr_prescale");
    apb(0, 8'h08, 0, 32'hABCD, 0, "rd_prescale");

    for (int i = 0; i < 5; i++)
      apb(1, 8'h10, {24'h0, txb[i]}, 0, (i == 4) ? ERR_EN : 1'b0, "wr_tx");
    apb(0, 8'h0C, 0, 32'h09, 0, "rd_status_txfull");
    for (int i = 0; i < 4; i++) begin
      @(negedge apb_clk);
      chk("tx_valid_drain", {31'h0, tx_valid}, 32'h1);
      chk("tx_data_drain", {24'h0, tx_data}, {24'h0, txb[i]});
      tx_ready = 1'b1;
      @(posedge apb_clk); #1;
      tx_ready = 1'b0;
    end
    @(negedge apb_clk) chk("tx_empty_after_drain", {31'h0, tx_valid}, 32'h0);

    apb(0, 8'h10, 0, 32'h0, ERR_EN, "rd_txdata");
    apb(1, 8'h14, 32'hFF, 0, ERR_EN, "wr_rxdata");
    apb(0, 8'h18, 0, 32'h0, ERR_EN, "rd_unmapped");
    apb(0, 8'h48, 0, 32'h0, ERR_EN, "rd_upper_bits");
    apb(1, 8'h44, 32'h7F, 0, ERR_EN, "wr_upper_bits");
    apb(0, 8'h04, 0, 32'h5A, 0, "rd_saddr_unchanged");

    @(negedge apb_clk) chk("irq_idle", {31'h0, irq}, 32'h0);
    for (int i = 0; i < 5; i++) begin
      @(posedge apb_clk); #1;
      rx_valid = 1'b1;
      rx_data  = rxb[i];
    end
    @(posedge apb_clk); #1;
    rx_valid = 1'b0;
    @(negedge apb_clk);
    @(negedge apb_clk) chk("irq_rx", {31'h0, irq}, 32'h1);
    apb(0, 8'h0C, 0, 32'h16, 0, "rd_status_ovf");
    apb(1, 8'h0C, 32'h10, 0, 0, "w1c_ovf");
    apb(0, 8'h0C, 0, 32'h06, 0, "rd_status_ovf_clr");

    apb(0, 8'h14, 0, 32'hA1, 0, "rd_rx_push_pop", 1'b1, 8'hB5);
    apb(0, 8'h0C, 0, 32'h06, 0, "rd_status_still_full");
    apb(0, 8'h14, 0, 32'hA2, 0, "rd_rx2");
    apb(0, 8'h14, 0, 32'hA3, 0, "rd_rx3");
    apb(0, 8'h14, 0, 32'hA4, 0, "rd_rx4");
    apb(0, 8'h14, 0, 32'hB5, 0, "rd_rx5");
    apb(0, 8'h0C, 0, 32'h0A, 0, "rd_status_empty");
    apb(0, 8'h14, 0, 32'h0, ERR_EN, "rd_rx_empty");
    @(negedge apb_clk) chk("irq_cleared", {31'h0, irq}, 32'h0);

    apb(1, 8'h10, 32'h77, 0, 0, "wr_tx_pre_rst");
    @(posedge apb_clk); #1;
    rx_valid = 1'b1; rx_data = 8'hC3;
    @(posedge apb_clk); #1;
    rx_valid = 1'b0;
    @(negedge apb_clk);
    @(negedge apb_clk);
    chk("pre_rst_tx_valid", {31'h0, tx_valid}, 32'h1);
    chk("pre_rst_irq", {31'h0, irq}, 32'h1);
    @(posedge apb_clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h08;
    @(posedge apb_clk); #1;
    penable = 1'b1;
    @(negedge apb_clk);
    @(negedge apb_clk);
    chk("pre_rst_prdata", prdata, 32'hABCD);
    preset_n = 1'b0;
    #1;
    chk("mid_rst_prdata", prdata, 32'h0);
    chk("mid_rst_pready", {31'h0, pready}, 32'h0);
    chk("mid_rst_irq", {31'h0, irq}, 32'h0);
    chk("mid_rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    chk("mid_rst_ctrl_en", {31'h0, ctrl_en}, 32'h0);
    chk("mid_rst_saddr", {25'h0, slave_addr}, 32'h0);
    chk("mid_rst_prescale", {16'h0, prescale}, 32'h63);
    @(posedge apb_clk); #1;
    psel = 1'b0; penable = 1'b0;
    @(negedge apb_clk);
    preset_n = 1'b1;
    apb(0, 8'h08, 0, 32'h63, 0, "rd_prescale_after_rst");
    apb(0, 8'h0C, 0, 32'h0A, 0, "rd_status_after_rst");

    @(negedge apb_clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
